// File: rtl/aes_pkg.sv
// Shared AES definitions for the AES-CTR core.
// Contents:
//   aes_word_t / aes_block_t : 32-bit AES word and 128-bit AES block types
//   NUM_ROUNDS               : AES-128 round count (10)
//   RCON                     : round constants Rcon[1..10], stored at index i-1
//   rot_word()               : AES RotWord, a one-byte left rotation of a word
package aes_pkg;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;

  localparam int NUM_ROUNDS = 10;

  localparam logic [7:0] RCON [0:NUM_ROUNDS-1] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // {b0,b1,b2,b3} -> {b1,b2,b3,b0}, where b0 is the most significant byte
  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, implemented as a 256-entry ROM.
// Ports:
//   addr  in  8  input byte
//   data  out 8  substituted byte
module aes_sbox (
  input  logic [7:0] addr,
  output logic [7:0] data
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign data = SBOX[addr];

endmodule

// File: rtl/key_expansion_128.sv
// Iterative AES-128 key schedule. A start pulse loads the cipher key as
// round key 0; round keys 1..10 are then produced one per clock. All 11
// keys live in a register file and are read through a combinational mux.
// Ports:
//   clk            in   1    rising-edge clock
//   rst            in   1    asynchronous active-high reset
//   start          in   1    one-cycle pulse: capture key_in and (re)start
//   key_in         in   128  cipher key, [127:96] = w0 ... [31:0] = w3
//   round          in   4    round-key select 0..10 (11..15 read as zero)
//   round_key_out  out  128  selected round key
//   ready          out  1    all 11 round keys valid
// Build option:
//   KEYEXP_ZEROIZE_EN - when defined, a start also clears round keys 1..10 so
//                       keys derived from a previous cipher key cannot be read
//                       while the new schedule is being generated.
module key_expansion_128
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [3:0]   round,
  output logic [127:0] round_key_out,
  output logic         ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0] state;
  logic [3:0] cnt;
  aes_block_t rk [0:NUM_ROUNDS];

  aes_block_t prev;
  logic [7:0] rcon;
  aes_word_t  rot;
  aes_word_t  sub;
  aes_word_t  t;
  aes_word_t  n0, n1, n2, n3;
  aes_block_t next_key;

  // cnt names the key being generated; the previous key feeds the round function
  always_comb begin
    prev = '0;
    rcon = '0;
    for (int i = 0; i < NUM_ROUNDS; i++) begin
      if (cnt == 4'(i + 1)) begin
        prev = rk[i];
        rcon = RCON[i];
      end
    end
  end

  assign rot = rot_word(prev[31:0]);

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .addr (rot[8*b +: 8]),
      .data (sub[8*b +: 8])
    );
  end

  assign t  = sub ^ {rcon, 24'h0};
  assign n0 = prev[127:96] ^ t;
  assign n1 = prev[95:64]  ^ n0;
  assign n2 = prev[63:32]  ^ n1;
  assign n3 = prev[31:0]   ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ready <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
    end else if (start) begin
      // start wins in every state, so a start during BUSY restarts cleanly
      state <= ST_BUSY;
      cnt   <= 4'd1;
      ready <= 1'b0;
      rk[0] <= key_in;
`ifdef KEYEXP_ZEROIZE_EN
      for (int i = 1; i <= NUM_ROUNDS; i++) rk[i] <= '0;
`endif
    end else if (state == ST_BUSY) begin
      for (int i = 1; i <= NUM_ROUNDS; i++) begin
        if (cnt == 4'(i)) rk[i] <= next_key;
      end
      if (cnt == 4'(NUM_ROUNDS)) begin
        state <= ST_DONE;
        ready <= 1'b1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  always_comb begin
    round_key_out = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (round == 4'(i)) round_key_out = rk[i];
    end
  end

endmodule

// File: tb/tb_key_expansion_128.sv
// Self-checking bench for key_expansion_128. Stimulus pushes expected
// ready/key values into a scoreboard queue; a monitor on the falling edge
// pops each entry and compares it against the live DUT outputs.
module tb_key_expansion_128;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic [3:0]   round;
  logic [127:0] round_key_out;
  logic         ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        name;
    bit           chk_key;
    logic [127:0] key;
    bit           chk_rdy;
    logic         rdy;
  } exp_t;

  exp_t sb [$];

  logic [127:0] a1 [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  logic [127:0] zero_rk10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  key_expansion_128 dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .key_in        (key_in),
    .round         (round),
    .round_key_out (round_key_out),
    .ready         (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every pending expectation at the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk_rdy) begin
          checks++;
          if (ready !== e.rdy) begin
            errors++;
            $display("FAIL %s: ready=%b expected %b", e.name, ready, e.rdy);
          end
        end
        if (e.chk_key) begin
          checks++;
          if (round_key_out !== e.key) begin
            errors++;
            $display("FAIL %s: round=%0d key=%h expected %h", e.name, round, round_key_out, e.key);
          end
        end
      end
    end
  end

  task automatic push_rdy(input string name, input logic r);
    exp_t e;
    e.name = name; e.chk_key = 1'b0; e.key = '0; e.chk_rdy = 1'b1; e.rdy = r;
    sb.push_back(e);
  endtask

  // Select a round, queue its expected key, and hold it until sampled
  task automatic expect_key(input string name, input int r, input logic [127:0] k);
    exp_t e;
    round = 4'(r);
    e.name = name; e.chk_key = 1'b1; e.key = k; e.chk_rdy = 1'b0; e.rdy = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  // Returns just after the edge that captures k; key_in is then scrambled
  task automatic pulse_start(input logic [127:0] k);
    @(posedge clk); #1;
    start  = 1'b1;
    key_in = k;
    @(posedge clk); #1;
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Called right after the start edge: ready low for 10 samples, then high
  task automatic check_latency(input string name);
    push_rdy(name, 1'b0);
    for (int k = 1; k < 10; k++) begin
      @(posedge clk); #1;
      push_rdy(name, 1'b0);
    end
    @(posedge clk); #1;
    push_rdy(name, 1'b1);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    key_in = '0;
    round  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    push_rdy("reset_ready", 1'b0);
    expect_key("reset_rk0", 0, 128'h0);
    expect_key("reset_rk10", 10, 128'h0);
    rst = 1'b0;

    // FIPS-197 A.1 load
    pulse_start(a1[0]);
    check_latency("a1_latency");
    expect_key("a1_rk0", 0, a1[0]);
    expect_key("a1_rk1", 1, a1[1]);
    expect_key("a1_rk5", 5, a1[5]);
    expect_key("a1_rk10", 10, a1[10]);

    // Full sweep plus out-of-range selects, ready held
    repeat (3) @(posedge clk);
    #1;
    push_rdy("a1_ready_hold", 1'b1);
    for (int r = 0; r <= 10; r++) expect_key($sformatf("sweep_rk%0d", r), r, a1[r]);
    expect_key("sweep_rk11", 11, 128'h0);
    expect_key("sweep_rk15", 15, 128'h0);

    // Restart with key 0 while busy
    pulse_start(a1[0]);
    push_rdy("restart_busy", 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      push_rdy("restart_busy", 1'b0);
    end
    pulse_start(128'h0);
    check_latency("restart_latency");
    expect_key("restart_rk0", 0, 128'h0);
    expect_key("restart_rk10", 10, zero_rk10);

    // Reset mid-expansion
    pulse_start(a1[0]);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    push_rdy("midrst_ready", 1'b0);
    expect_key("midrst_rk0", 0, 128'h0);
    expect_key("midrst_rk1", 1, 128'h0);
    expect_key("midrst_rk10", 10, 128'h0);
    rst = 1'b0;
    pulse_start(a1[0]);
    check_latency("postrst_latency");
    expect_key("postrst_rk3", 3, a1[3]);
    expect_key("postrst_rk10", 10, a1[10]);

    // Reload with key 0: stale keys visible only without zeroize
    pulse_start(128'h0);
`ifdef KEYEXP_ZEROIZE_EN
    expect_key("reload_rk10", 10, 128'h0);
    expect_key("reload_rk5", 5, 128'h0);
`else
    expect_key("reload_rk10", 10, a1[10]);
    expect_key("reload_rk5", 5, a1[5]);
`endif
    expect_key("reload_rk0", 0, 128'h0);
    repeat (12) @(posedge clk);
    #1;
    push_rdy("reload_ready", 1'b1);
    expect_key("reload_final_rk10", 10, zero_rk10);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 100 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
